// File: rtl/unidade_acesso_memoria_pkg.sv
// Shared definitions for the load/store sequencer and the 8-bit data memory.
// Holds the sequencer state encoding, access-size codes and default widths.
// No logic here; imported by the sequencer and the memory.
package pkg_acesso_memoria;

    localparam int LARGURA_END  = 8;
    localparam int LARGURA_BYTE = 8;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        BYTE0     = 2'd1,
        BYTE1     = 2'd2,
        CONCLUIDO = 2'd3
    } estado_t;

    localparam logic TAM_BYTE = 1'b0;
    localparam logic TAM_MEIA = 1'b1;

endpackage

// File: rtl/unidade_acesso_memoria.sv
// Load/store sequencer: splits a byte or little-endian halfword request into byte accesses.
// Latency: byte -> pronto in 2nd cycle after accept, halfword -> 3rd cycle.
// Backpressure: requests are only sampled in OCIOSO; anything offered while ocupado is dropped.
module unidade_acesso_memoria
    import pkg_acesso_memoria::*;
#(
    parameter int LARGURA_END  = pkg_acesso_memoria::LARGURA_END,
    parameter int LARGURA_BYTE = pkg_acesso_memoria::LARGURA_BYTE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valido,
    input  logic                        req_escrita,
    input  logic                        req_meia,
    input  logic                        req_sinal,
    input  logic [LARGURA_END-1:0]      req_endereco,
    input  logic [2*LARGURA_BYTE-1:0]   req_dado,
    output logic                        ocupado,
    output logic                        pronto,
    output logic [2*LARGURA_BYTE-1:0]   dado_lido,
    output logic                        mem_habilita_escrita,
    output logic                        mem_habilita_leitura,
    output logic [LARGURA_END-1:0]      mem_endereco,
    output logic [LARGURA_BYTE-1:0]     mem_dado_entrada,
    input  logic [LARGURA_BYTE-1:0]     mem_dado_saida
);

    estado_t                      estado, proximo;
    logic                         escrita_r, meia_r, sinal_r;
    logic [LARGURA_END-1:0]       end_r;
    logic [2*LARGURA_BYTE-1:0]    dado_r;
    logic [LARGURA_BYTE-1:0]      lo_r;
    logic [2*LARGURA_BYTE-1:0]    lido_r;
    logic                         aceita;

    assign aceita = (estado == OCIOSO) && req_valido;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= proximo;
    end

    // Next-state: one or two byte phases, then a single completion cycle
    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:    if (req_valido) proximo = BYTE0;
            BYTE0:     proximo = (meia_r == TAM_MEIA) ? BYTE1 : CONCLUIDO;
            BYTE1:     proximo = CONCLUIDO;
            CONCLUIDO: proximo = OCIOSO;
            default:   proximo = OCIOSO;
        endcase
    end

    // Capture the request on the accepting edge; low byte of a load on BYTE0's closing edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            escrita_r <= 1'b0;
            meia_r    <= 1'b0;
            sinal_r   <= 1'b0;
            end_r     <= '0;
            dado_r    <= '0;
            lo_r      <= '0;
        end else begin
            if (aceita) begin
                escrita_r <= req_escrita;
                meia_r    <= req_meia;
                sinal_r   <= req_sinal;
                end_r     <= req_endereco;
                dado_r    <= req_dado;
            end
            if (estado == BYTE0 && !escrita_r)
                lo_r <= mem_dado_saida;
        end
    end

    // Load result is assembled on the edge entering CONCLUIDO; the last byte comes straight
    // from the memory so no extra cycle is spent registering it first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lido_r <= '0;
        end else if (!escrita_r) begin
            if (estado == BYTE0 && meia_r == TAM_BYTE) begin
                if (sinal_r)
                    lido_r <= {{LARGURA_BYTE{mem_dado_saida[LARGURA_BYTE-1]}}, mem_dado_saida};
                else
                    lido_r <= {{LARGURA_BYTE{1'b0}}, mem_dado_saida};
            end else if (estado == BYTE1) begin
                lido_r <= {mem_dado_saida, lo_r};
            end
        end
    end

    assign dado_lido = lido_r;

    // Moore decode of the memory pins from state and latched request only
    always_comb begin
        ocupado              = (estado != OCIOSO);
        pronto               = (estado == CONCLUIDO);
        mem_habilita_escrita = 1'b0;
        mem_habilita_leitura = 1'b0;
        mem_endereco         = '0;
        mem_dado_entrada     = '0;
        case (estado)
            BYTE0: begin
                mem_endereco = end_r;
                if (escrita_r) begin
                    mem_habilita_escrita = 1'b1;
                    mem_dado_entrada     = dado_r[LARGURA_BYTE-1:0];
                end else begin
                    mem_habilita_leitura = 1'b1;
                end
            end
            BYTE1: begin
                // Wraps modulo 2^LARGURA_END by construction of the adder width
                mem_endereco = end_r + {{(LARGURA_END-1){1'b0}}, 1'b1};
                if (escrita_r) begin
                    mem_habilita_escrita = 1'b1;
                    mem_dado_entrada     = dado_r[2*LARGURA_BYTE-1:LARGURA_BYTE];
                end else begin
                    mem_habilita_leitura = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidade_acesso_memoria.sv
module tb_unidade_acesso_memoria;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valido, req_escrita, req_meia, req_sinal;
    logic [7:0]  req_endereco;
    logic [15:0] req_dado;
    logic        ocupado, pronto;
    logic [15:0] dado_lido;
    logic        we, re;
    logic [7:0]  mem_endereco, mem_dado_entrada, mem_dado_saida;

    unidade_acesso_memoria dut (
        .clk                  (clk),
        .reset                (reset),
        .req_valido           (req_valido),
        .req_escrita          (req_escrita),
        .req_meia             (req_meia),
        .req_sinal            (req_sinal),
        .req_endereco         (req_endereco),
        .req_dado             (req_dado),
        .ocupado              (ocupado),
        .pronto               (pronto),
        .dado_lido            (dado_lido),
        .mem_habilita_escrita (we),
        .mem_habilita_leitura (re),
        .mem_endereco         (mem_endereco),
        .mem_dado_entrada     (mem_dado_entrada),
        .mem_dado_saida       (mem_dado_saida)
    );

    always #5 clk = ~clk;

    // Data memory model: combinational read, write on rising edge
    logic [7:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    always @(posedge clk) if (we) mem[mem_endereco] <= mem_dado_entrada;
    assign mem_dado_saida = mem[mem_endereco];

    typedef struct {
        logic [15:0] lido;
        int          lat;
    } esperado_t;

    esperado_t sb[$];
    int total = 0;
    int bad   = 0;
    int lat_cnt = 0;
    logic prev_ocup = 1'b0;
    int n_we = 0;
    logic [15:0] exp_lido;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] exigido);
        total++;
        if (atual !== exigido) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nome, atual, exigido);
        end
    endtask

    // Monitor: pops the scoreboard on every pronto and checks protocol invariants
    always @(negedge clk) begin
        if (reset) begin
            lat_cnt   = 0;
            prev_ocup = 1'b0;
        end else begin
            if (ocupado && !prev_ocup) lat_cnt = 1;
            else if (ocupado)          lat_cnt++;
            prev_ocup = ocupado;
            if (we) n_we++;
            if (ocupado) chk("we_re_exclusive", {31'd0, we & re}, 32'd0);
            if (pronto) begin
                chk("no_enable_in_concluido", {30'd0, we, re}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_pronto", 32'd1, 32'd0);
                end else begin
                    esperado_t e;
                    e = sb.pop_front();
                    chk("dado_lido_at_pronto", {16'd0, dado_lido}, {16'd0, e.lido});
                    chk("latency", lat_cnt, e.lat);
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ocupado) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic escrita, input logic meia, input logic sinal,
                         input logic [7:0] endereco, input logic [15:0] dado,
                         input logic [15:0] lido, input int lat);
        esperado_t e;
        req_valido   = 1'b1;
        req_escrita  = escrita;
        req_meia     = meia;
        req_sinal    = sinal;
        req_endereco = endereco;
        req_dado     = dado;
        e.lido = lido;
        e.lat  = lat;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valido = 1'b0;
        wait_idle();
    endtask

    initial begin
        reset = 1'b1;
        req_valido = 1'b0; req_escrita = 1'b0; req_meia = 1'b0; req_sinal = 1'b0;
        req_endereco = 8'h00; req_dado = 16'h0000;
        exp_lido = 16'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ocupado", {31'd0, ocupado}, 32'd0);
        chk("reset_pronto", {31'd0, pronto}, 32'd0);
        chk("reset_dado_lido", {16'd0, dado_lido}, 32'd0);
        chk("reset_mem_pins", {14'd0, we, re, mem_endereco, mem_dado_entrada}, 32'd0);

        // Byte store
        n_we = 0;
        issue(1'b1, 1'b0, 1'b0, 8'h10, 16'h00A5, exp_lido, 2);
        chk("byte_store_mem", {24'd0, mem[8'h10]}, 32'h0A5);
        chk("byte_store_we_cycles", n_we, 1);

        // Halfword store then load
        n_we = 0;
        issue(1'b1, 1'b1, 1'b0, 8'h20, 16'hBEEF, exp_lido, 3);
        chk("half_store_lo", {24'd0, mem[8'h20]}, 32'hEF);
        chk("half_store_hi", {24'd0, mem[8'h21]}, 32'hBE);
        chk("half_store_we_cycles", n_we, 2);
        exp_lido = 16'hBEEF;
        issue(1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, exp_lido, 3);
        repeat (3) @(negedge clk);
        chk("half_load_held", {16'd0, dado_lido}, 32'hBEEF);

        // Byte loads of 0x80, signed and unsigned
        issue(1'b1, 1'b0, 1'b0, 8'h30, 16'h5580, exp_lido, 2);
        exp_lido = 16'hFF80;
        issue(1'b0, 1'b0, 1'b1, 8'h30, 16'h0000, exp_lido, 2);
        exp_lido = 16'h0080;
        issue(1'b0, 1'b0, 1'b0, 8'h30, 16'h0000, exp_lido, 2);

        // Address wrap
        issue(1'b1, 1'b1, 1'b0, 8'hFF, 16'h1234, exp_lido, 3);
        chk("wrap_store_ff", {24'd0, mem[8'hFF]}, 32'h34);
        chk("wrap_store_00", {24'd0, mem[8'h00]}, 32'h12);
        exp_lido = 16'h1234;
        issue(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, exp_lido, 3);

        // Busy rejection: request held high with a new address every cycle
        req_valido = 1'b1; req_escrita = 1'b0; req_meia = 1'b0; req_sinal = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("busy_ocupado", {31'd0, ocupado}, {31'd0, (k % 3) != 0});
            req_endereco = 8'h50 + 8'(k);
            if ((k % 3) == 0) begin
                esperado_t e;
                exp_lido = {8'h00, (8'h50 + 8'(k)) ^ 8'h5A};
                e.lido = exp_lido;
                e.lat  = 2;
                sb.push_back(e);
            end
            @(negedge clk);
        end
        req_valido = 1'b0;
        wait_idle();
        chk("busy_queue_drained", sb.size(), 0);

        // Reset in BYTE1 of a halfword store
        req_valido = 1'b1; req_escrita = 1'b1; req_meia = 1'b1;
        req_endereco = 8'h40; req_dado = 16'hCAFE;
        @(posedge clk);
        #1 req_valido = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_ocupado", {31'd0, ocupado}, 32'd0);
        chk("async_reset_mem_pins", {14'd0, we, re, mem_endereco, mem_dado_entrada}, 32'd0);
        chk("async_reset_dado_lido", {16'd0, dado_lido}, 32'd0);
        exp_lido = 16'h0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_store_lo_written", {24'd0, mem[8'h40]}, 32'hFE);
        chk("reset_store_hi_untouched", {24'd0, mem[8'h41]}, 32'h1B);

        // Normal operation after reset
        exp_lido = 16'hFFFE;
        issue(1'b0, 1'b0, 1'b1, 8'h40, 16'h0000, exp_lido, 2);
        chk("final_queue_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unidade_acesso_memoria.md
Name: unidade_acesso_memoria

Overview:
- Initiator-side load/store sequencer for the 8-bit, 256-byte data memory; sits between the datapath (LW/SW control) and the memory's MemWrite/MemRead/address/data pins.
- Accepts one byte or halfword (16-bit, little-endian) request and splits it into one or two byte accesses.
- Reports completion with a one-cycle pulse and holds the assembled read data until the next load completes.

Parameters:
- LARGURA_END, 8, memory address width; addresses wrap modulo 2^LARGURA_END.
- LARGURA_BYTE, 8, memory data width; the halfword is 2*LARGURA_BYTE.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valido  input  1  request strobe; sampled only in OCIOSO.
- req_escrita  input  1  1 = store, 0 = load.
- req_meia  input  1  1 = halfword, 0 = byte.
- req_sinal  input  1  loads only: sign-extend a byte load into dado_lido.
- req_endereco  input  8  base byte address.
- req_dado  input  16  store data; a byte store uses bits [7:0].
- ocupado  output  1  high while a request is in progress.
- pronto  output  1  one-cycle completion pulse.
- dado_lido  output  16  load result; held between loads.
- mem_habilita_escrita  output  1  to memory MemWrite.
- mem_habilita_leitura  output  1  to memory MemRead.
- mem_endereco  output  8  to memory address.
- mem_dado_entrada  output  8  to memory write data.
- mem_dado_saida  input  8  from memory read data (combinational, same cycle as the address).

Behaviour:
- States: OCIOSO, BYTE0, BYTE1, CONCLUIDO.
- Transitions:
  - OCIOSO -> BYTE0 on req_valido=1. On that edge, latch tipo (escrita, meia, sinal), endereco and dado.
  - BYTE0 -> BYTE1 if meia=1, else BYTE0 -> CONCLUIDO.
  - BYTE1 -> CONCLUIDO.
  - CONCLUIDO -> OCIOSO unconditionally.
- Memory-side outputs are Moore outputs decoded only from state and latched registers. There is no combinational path from req_* to mem_*.
- BYTE0:
  - mem_endereco = end_latched.
  - Store: mem_habilita_escrita=1, mem_dado_entrada = dado[7:0].
  - Load: mem_habilita_leitura=1; capture mem_dado_saida into low byte on the closing edge.
- BYTE1:
  - mem_endereco = end_latched+1, mod 256. Address 0xFF wraps to 0x00; no error flag.
  - Store: mem_dado_entrada = dado[15:8].
  - Load: capture mem_dado_saida into high byte.
- In OCIOSO and CONCLUIDO, both enables are 0; mem_endereco and mem_dado_entrada are 0.
- Never assert mem_habilita_escrita and mem_habilita_leitura in the same cycle.
- CONCLUIDO:
  - pronto=1.
  - For a load, dado_lido is updated on the edge entering CONCLUIDO:
    - Halfword: {hi, lo}.
    - Byte, sinal=1: {8{lo[7]}, lo}.
    - Byte, sinal=0: {8'h00, lo}.
  - A store never changes dado_lido.
- ocupado = 1 in BYTE0, BYTE1 and CONCLUIDO.
- req_valido while ocupado=1 is ignored; there is no queueing. The datapath holds or reissues it.
- Latency, counted from the accepting edge: byte request, pronto in the 2nd cycle; halfword request, pronto in the 3rd cycle. Back-to-back throughput: one byte request per 3 cycles, one halfword request per 4 cycles.
- Reset (asynchronous, any state):
  - State -> OCIOSO.
  - ocupado, pronto, all mem_* outputs, dado_lido and latched registers -> 0.
  - Mid-halfword store: a byte already written at an earlier edge stays in memory; the second byte is not written. No pronto is produced.
- While reset is high, req_valido is ignored.

Decomposition:
- Shared package pkg_acesso_memoria:
  - State enum: OCIOSO=2'd0, BYTE0=2'd1, BYTE1=2'd2, CONCLUIDO=2'd3.
  - Constants TAM_BYTE=1'b0, TAM_MEIA=1'b1.
  - LARGURA_END/LARGURA_BYTE defaults, reused by the data memory and this block.
- No sub-module: the FSM, latches and sign-extension fit in one module of about 150-200 lines.

Test Plan:
- Byte store: req(escrita=1, meia=0, end=0x10, dado=0x00A5) -> exactly one cycle with we=1, addr=0x10, din=0xA5; pronto 2nd cycle; memory[0x10]=0xA5; dado_lido unchanged.
- Halfword store then halfword load at 0x20, dado=0xBEEF:
  - Store -> mem[0x20]=0xEF, mem[0x21]=0xBE; pronto 3rd cycle.
  - Load -> dado_lido=0xBEEF in the pronto cycle and held afterwards.
- Byte load of mem[0x30]=0x80:
  - sinal=1 -> dado_lido=0xFF80.
  - sinal=0 -> dado_lido=0x0080.
- Wrap-around: halfword store end=0xFF, dado=0x1234 -> mem[0xFF]=0x34, mem[0x00]=0x12; halfword load end=0xFF -> 0x1234.
- Busy rejection: keep req_valido=1 constantly with changing addresses -> requests accepted only in OCIOSO cycles (every 3/4 cycles); no enable ever asserted in CONCLUIDO; we and re never both high.
- Reset in BYTE1 of a halfword store 0xCAFE at 0x40 -> outputs 0 immediately (asynchronously); mem[0x40]=0xFE, mem[0x41] unchanged; no pronto; next request after reset completes normally.
